tt_pattern_bus_arbiter: RTL and testbench

//  Shares one DW-bit output pattern bus (dedicated outputs + bidir IOs) between NREQ

---
 rtl/tt_pattern_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_tt_pattern_bus_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tt_pattern_bus_arbiter.sv
// Round-robin arbiter sharing one pattern output bus between test sources.
// Bounded dwell per grant, one-cycle turnaround gap, optional forced source.
module tt_pattern_bus_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int DWELL = 16,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int TW = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    done,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic             force_en,
  input  logic [IW-1:0]    force_sel,
  output logic [NREQ-1:0]  gnt,
  output logic [IW-1:0]    gnt_idx,
  output logic [DW-1:0]    bus_data,
  output logic [DW-1:0]    bus_oe,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic [1:0] sync;
  logic arst_n;

  state_t state, state_n;
  logic [NREQ-1:0] gnt_n;
  logic [IW-1:0] idx_n;
  logic [IW-1:0] last, last_n;
  logic [TW-1:0] timer, timer_n;
  logic forced, forced_n;

  logic [IW-1:0] fsel;
  logic [IW-1:0] win;
  logic any;
  int k;
  logic timeout;
  logic rel;

  // Async assert, synchronous release of the internal reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], 1'b1};
  end

  assign arst_n = sync[1];

  always_comb begin
    fsel = force_sel;
    if (int'(force_sel) >= NREQ) fsel = '0;
  end

  always_comb begin
    any = 1'b0;
    win = '0;
    k = 0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(last) + i) % NREQ;
      if (!any && req[k]) begin
        any = 1'b1;
        win = IW'(k);
      end
    end
  end

  assign timeout = (timer == TW'(DWELL - 1));

  always_comb begin
    rel = done[gnt_idx];
    if (force_en && (fsel != gnt_idx)) rel = 1'b1;
    if (forced) begin
      if (!force_en) rel = 1'b1;
    end else begin
      if (!req[gnt_idx] || timeout) rel = 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    idx_n    = gnt_idx;
    timer_n  = timer;
    last_n   = last;
    forced_n = forced;
    unique case (state)
      IDLE: begin
        if (force_en) begin
          state_n  = GRANT;
          idx_n    = fsel;
          gnt_n    = ONE << fsel;
          timer_n  = '0;
          forced_n = 1'b1;
        end else if (any) begin
          state_n  = GRANT;
          idx_n    = win;
          gnt_n    = ONE << win;
          timer_n  = '0;
          forced_n = 1'b0;
        end
      end
      GRANT: begin
        if (rel) begin
          state_n = GAP;
          gnt_n   = '0;
          idx_n   = '0;
          last_n  = gnt_idx;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      timer   <= '0;
      last    <= IW'(NREQ - 1);
      forced  <= 1'b0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      gnt_idx <= idx_n;
      timer   <= timer_n;
      last    <= last_n;
      forced  <= forced_n;
    end
  end

  assign bus_oe   = (state == GRANT) ? '1 : '0;
  assign bus_data = (state == GRANT) ? req_data[gnt_idx*DW +: DW] : '0;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_tt_pattern_bus_arbiter.sv
// Bench for tt_pattern_bus_arbiter: vector table of timed segments,
// expected outputs queued at drive time and compared at the next negedge.
module tb_tt_pattern_bus_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int DWELL = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [31:0] req_data;
  logic force_en;
  logic [1:0] force_sel;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic [7:0] bus_data;
  logic [7:0] bus_oe;
  logic busy;

  always #5 clk = ~clk;

  tt_pattern_bus_arbiter #(
    .NREQ(NREQ), .DW(DW), .DWELL(DWELL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .done(done),
    .req_data(req_data),
    .force_en(force_en),
    .force_sel(force_sel),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .bus_data(bus_data),
    .bus_oe(bus_oe),
    .busy(busy)
  );

  typedef struct {
    logic rst;
    logic [3:0] rq;
    logic [3:0] dn;
    logic fe;
    logic [1:0] fs;
    logic [3:0] g;
    logic b;
    int n;
  } vec_t;

  typedef struct {
    logic [3:0] g;
    logic b;
  } exp_t;

  vec_t vt[$];
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int split;
  logic [7:0] dat [4];

  function automatic void add(logic rst, logic [3:0] rq, logic [3:0] dn,
                              logic fe, logic [1:0] fs, logic [3:0] g,
                              logic b, int n);
    vec_t v;
    v.rst = rst; v.rq = rq; v.dn = dn; v.fe = fe;
    v.fs = fs; v.g = g; v.b = b; v.n = n;
    vt.push_back(v);
  endfunction

  // Full grant of n cycles, then the gap and idle cycles.
  function automatic void gseg(logic [3:0] rq, logic [3:0] g, int n);
    add(1, rq, 0, 0, 0, g, 1, n);
    add(1, rq, 0, 0, 0, 0, 1, 1);
    add(1, rq, 0, 0, 0, 0, 0, 1);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req_v);
    end
  endtask

  task automatic check_out(exp_t e);
    logic [1:0] ei;
    logic [7:0] ed;
    ei = 2'd0;
    for (int i = 0; i < 4; i++) if (e.g[i]) ei = 2'(i);
    ed = (e.g != 4'b0) ? dat[ei] : 8'h00;
    chk("gnt", 32'(gnt), 32'(e.g));
    chk("gnt_idx", 32'(gnt_idx), 32'(ei));
    chk("bus_data", 32'(bus_data), 32'(ed));
    chk("bus_oe", 32'(bus_oe), (e.g != 4'b0) ? 32'hFF : 32'h00);
    chk("busy", 32'(busy), 32'(e.b));
  endtask

  task automatic run_row(vec_t v);
    exp_t e;
    for (int c = 0; c < v.n; c++) begin
      rst_n = v.rst;
      req = v.rq;
      done = v.dn;
      force_en = v.fe;
      force_sel = v.fs;
      e.g = v.g;
      e.b = v.b;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      check_out(e);
    end
  endtask

  initial begin
    dat[0] = 8'h3C; dat[1] = 8'hA5; dat[2] = 8'h5A; dat[3] = 8'hC3;
    req_data = {dat[3], dat[2], dat[1], dat[0]};
    rst_n = 1'b0; req = '0; done = '0;
    force_en = 1'b0; force_sel = '0;

    // reset, release latency, timeout of src0, single requester src1
    add(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 2);
    add(1, 4'b0001, 0, 0, 0, 4'b0000, 0, 2);
    add(1, 4'b0001, 0, 0, 0, 4'b0001, 1, 16);
    add(1, 4'b0010, 0, 0, 0, 4'b0000, 1, 1);
    add(1, 4'b0010, 0, 0, 0, 4'b0000, 0, 1);
    gseg(4'b0010, 4'b0010, 16);
    add(1, 4'b0010, 0, 0, 0, 4'b0010, 1, 5);
    split = vt.size();

    // round robin from a fresh reset
    add(0, 4'b1111, 0, 0, 0, 4'b0000, 0, 1);
    add(1, 4'b1111, 0, 0, 0, 4'b0000, 0, 2);
    gseg(4'b1111, 4'b0001, 16);
    gseg(4'b1111, 4'b0010, 16);
    gseg(4'b1111, 4'b0100, 16);
    gseg(4'b1111, 4'b1000, 16);
    add(1, 4'b1111, 0, 0, 0, 4'b0001, 1, 16);
    add(1, 4'b0100, 0, 0, 0, 4'b0000, 1, 1);
    add(1, 4'b0100, 0, 0, 0, 4'b0000, 0, 1);
    // early release of src2, stray done[1]
    add(1, 4'b0100, 0, 0, 0, 4'b0100, 1, 1);
    add(1, 4'b0100, 4'b0010, 0, 0, 4'b0100, 1, 1);
    add(1, 4'b0100, 0, 0, 0, 4'b0100, 1, 2);
    add(1, 4'b0100, 4'b0100, 0, 0, 4'b0000, 1, 1);
    add(1, 4'b0001, 0, 0, 0, 4'b0000, 0, 1);
    // force src3 during a src0 grant
    add(1, 4'b0001, 0, 0, 0, 4'b0001, 1, 2);
    add(1, 4'b0001, 0, 1, 3, 4'b0000, 1, 1);
    add(1, 4'b0001, 0, 1, 3, 4'b0000, 0, 1);
    add(1, 4'b0001, 0, 1, 3, 4'b1000, 1, 110);
    add(1, 4'b0001, 0, 0, 0, 4'b0000, 1, 1);
    add(1, 4'b0001, 0, 0, 0, 4'b0000, 0, 1);
    // done and dwell expiry in the same cycle
    add(1, 4'b0001, 0, 0, 0, 4'b0001, 1, 16);
    add(1, 4'b0001, 4'b0001, 0, 0, 4'b0000, 1, 1);
    add(1, 4'b0001, 0, 0, 0, 4'b0000, 0, 1);
    add(1, 4'b0001, 0, 0, 0, 4'b0001, 1, 3);

    for (int i = 0; i < split; i++) run_row(vt[i]);

    // reset mid-grant drops the bus within the same cycle
    rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt), 32'h0);
    chk("async_oe", 32'(bus_oe), 32'h00);
    chk("async_data", 32'(bus_data), 32'h00);
    chk("async_busy", 32'(busy), 32'h0);

    for (int i = split; i < vt.size(); i++) run_row(vt[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
